// File: rtl/hist_pkg.sv
// Shared constants and FSM state type for the histogram engine.
// Optional feature macro used by this slice: HIST_CLIP_EN (per-bin clip limit).
package hist_pkg;

    localparam int unsigned PIX_W         = 8;
    localparam int unsigned NUM_BINS      = 256;
    localparam int unsigned BIN_W         = 32;
    localparam int unsigned BINS_PER_WORD = 4;
    localparam int unsigned PIX_PER_WORD  = 16;
    localparam int unsigned FLUSH_WORDS   = 64;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        COUNT,
        FLUSH,
        DONE
    } hist_state_e;

endpackage

// File: rtl/hist_bin_bank.sv
// 256 x 32-bit saturating bin bank with single-cycle clear and a packed
// 4-bin read port. Build macro HIST_CLIP_EN adds a clip-limit compare.
module hist_bin_bank
    import hist_pkg::*;
(
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_clear,
    input  logic                                i_inc_en,
    input  logic [PIX_W-1:0]                    i_inc_idx,
    input  logic [5:0]                          i_rd_word,
`ifdef HIST_CLIP_EN
    input  logic [BIN_W-1:0]                    i_clip_limit,
    output logic                                o_clip_hit,
`endif
    output logic [BINS_PER_WORD*BIN_W-1:0]      o_rd_data
);

    logic [BIN_W-1:0] r_bins [NUM_BINS];
    logic [BIN_W-1:0] w_cur;
    logic             w_inc_ok;

    assign w_cur = r_bins[i_inc_idx];

    // Decide whether the addressed bin may grow (saturation, optional clip).
    always_comb begin
        w_inc_ok = (w_cur != '1);
`ifdef HIST_CLIP_EN
        o_clip_hit = i_inc_en && (i_clip_limit != '0) && (w_cur == i_clip_limit);
        if (o_clip_hit) begin
            w_inc_ok = 1'b0;
        end
`endif
    end

    // Bin storage: clear-all or a single saturating increment per cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < NUM_BINS; i++) begin
                r_bins[i] <= '0;
            end
        end else if (i_clear) begin
            for (int unsigned i = 0; i < NUM_BINS; i++) begin
                r_bins[i] <= '0;
            end
        end else if (i_inc_en && w_inc_ok) begin
            r_bins[i_inc_idx] <= w_cur + 32'd1;
        end
    end

    // Packed read: bin[4i] lands in the least significant lane.
    always_comb begin
        o_rd_data = '0;
        for (int unsigned b = 0; b < BINS_PER_WORD; b++) begin
            o_rd_data[b*BIN_W +: BIN_W] = r_bins[{i_rd_word, 2'(b)}];
        end
    end

endmodule

// File: rtl/histogram_engine.sv
// Grey-level histogram of a packed 8-bit pixel frame, flushed to scratch
// memory as 64 words of four 32-bit bins. Build macro HIST_CLIP_EN adds
// clip_limit / clip_excess ports.
module histogram_engine
    import hist_pkg::*;
#(
    parameter int unsigned RD_LAT       = 3,
    parameter int unsigned SCRATCH_BASE = 0
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           histogram_en,
    input  logic [16:0]    num_words,
    output logic [15:0]    histogram_input_mem_raddr0,
    output logic [15:0]    histogram_input_mem_raddr1,
    input  logic [127:0]   histogram_input_mem_rdata0,
    input  logic [127:0]   histogram_input_mem_rdata1,
    output logic [15:0]    histogram_scratch_mem_raddr0,
    output logic [15:0]    histogram_scratch_mem_raddr1,
    output logic [15:0]    histogram_scratch_mem_waddr,
    output logic [127:0]   histogram_scratch_mem_wdata,
    output logic           histogram_scratch_mem_WE,
    output logic           busy,
`ifdef HIST_CLIP_EN
    input  logic [31:0]    clip_limit,
    output logic [31:0]    clip_excess,
`endif
    output logic           hist_done
);

    hist_state_e    r_state, w_next;
    logic           r_en_d;
    logic [16:0]    r_words;
    logic [15:0]    r_pair;
    logic [7:0]     r_wait;
    logic [4:0]     r_pix;
    logic [5:0]     r_flush;
    logic [255:0]   r_shift;
    logic [15:0]    r_raddr0, r_raddr1;
    logic           w_start, w_last_pair, w_half, w_wait_last, w_pix_last, w_flush_last;
    logic [16:0]    w_words_clamped;
    logic [15:0]    w_issue_pair;
    logic [127:0]   w_bank_rd;

    assign w_start         = (r_state == IDLE) && histogram_en && !r_en_d;
    assign w_words_clamped = (num_words > 17'h10000) ? 17'h10000 : num_words;
    assign w_last_pair     = ({r_pair, 1'b0} + 17'd2) >= r_words;
    assign w_half          = ({r_pair, 1'b1} == r_words);
    assign w_wait_last     = (r_wait == 8'(RD_LAT - 1));
    assign w_pix_last      = (r_pix == (w_half ? 5'(PIX_PER_WORD - 1) : 5'(2*PIX_PER_WORD - 1)));
    assign w_flush_last    = (r_flush == 6'(FLUSH_WORDS - 1));
    assign w_issue_pair    = (r_state == IDLE) ? 16'd0 : r_pair + 16'd1;

    assign histogram_input_mem_raddr0   = r_raddr0;
    assign histogram_input_mem_raddr1   = r_raddr1;
    assign histogram_scratch_mem_raddr0 = '0;
    assign histogram_scratch_mem_raddr1 = '0;

`ifdef HIST_CLIP_EN
    logic        w_clip_hit;
    logic [31:0] r_clip_excess;
    assign clip_excess = r_clip_excess;

    hist_bin_bank u_bank (
        .i_clk        (clock),
        .i_rst_n      (reset_n),
        .i_clear      (w_start),
        .i_inc_en     (r_state == COUNT),
        .i_inc_idx    (r_shift[PIX_W-1:0]),
        .i_rd_word    (r_flush),
        .i_clip_limit (clip_limit),
        .o_clip_hit   (w_clip_hit),
        .o_rd_data    (w_bank_rd)
    );

    // Count suppressed increments for the current frame, saturating.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_clip_excess <= '0;
        end else if (w_start) begin
            r_clip_excess <= '0;
        end else if (w_clip_hit && (r_clip_excess != '1)) begin
            r_clip_excess <= r_clip_excess + 32'd1;
        end
    end
`else
    hist_bin_bank u_bank (
        .i_clk     (clock),
        .i_rst_n   (reset_n),
        .i_clear   (w_start),
        .i_inc_en  (r_state == COUNT),
        .i_inc_idx (r_shift[PIX_W-1:0]),
        .i_rd_word (r_flush),
        .o_rd_data (w_bank_rd)
    );
`endif

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and state-decoded outputs; a low enable aborts any frame.
    always_comb begin
        w_next                      = r_state;
        busy                        = 1'b0;
        hist_done                   = 1'b0;
        histogram_scratch_mem_WE    = 1'b0;
        histogram_scratch_mem_waddr = '0;
        histogram_scratch_mem_wdata = '0;
        unique case (r_state)
            IDLE:  if (w_start) w_next = (w_words_clamped == '0) ? FLUSH : ISSUE;
            ISSUE: begin
                busy   = 1'b1;
                w_next = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (w_wait_last) w_next = COUNT;
            end
            COUNT: begin
                busy = 1'b1;
                if (w_pix_last) w_next = w_last_pair ? FLUSH : ISSUE;
            end
            FLUSH: begin
                busy                        = 1'b1;
                histogram_scratch_mem_WE    = 1'b1;
                histogram_scratch_mem_waddr = 16'(SCRATCH_BASE) + {10'd0, r_flush};
                histogram_scratch_mem_wdata = w_bank_rd;
                if (w_flush_last) w_next = DONE;
            end
            DONE: begin
                hist_done = 1'b1;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if ((r_state != IDLE) && !histogram_en) begin
            w_next = IDLE;
        end
    end

    // Datapath: enable edge, frame length, read addresses, pixel shifter, counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_en_d   <= 1'b0;
            r_words  <= '0;
            r_pair   <= '0;
            r_wait   <= '0;
            r_pix    <= '0;
            r_flush  <= '0;
            r_shift  <= '0;
            r_raddr0 <= '0;
            r_raddr1 <= '0;
        end else begin
            r_en_d <= histogram_en;
            if (w_start) begin
                r_words <= w_words_clamped;
                r_pair  <= '0;
            end
            // Addresses are loaded on entry so they are already valid in ISSUE.
            if ((w_next == ISSUE) && (r_state != ISSUE)) begin
                r_raddr0 <= w_issue_pair << 1;
                r_raddr1 <= (w_issue_pair << 1) | 16'd1;
            end
            r_wait  <= (r_state == WAIT)  ? r_wait + 8'd1  : '0;
            r_pix   <= (r_state == COUNT) ? r_pix + 5'd1   : '0;
            r_flush <= (r_state == FLUSH) ? r_flush + 6'd1 : '0;
            if ((r_state == WAIT) && w_wait_last) begin
                r_shift <= {histogram_input_mem_rdata1, histogram_input_mem_rdata0};
            end else if (r_state == COUNT) begin
                r_shift <= r_shift >> PIX_W;
                if (w_pix_last && !w_last_pair) begin
                    r_pair <= r_pair + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_histogram_engine.sv
// Randomised self-checking bench for histogram_engine with a behavioural
// histogram model. Build macro HIST_CLIP_EN enables the clip ports.
module tb_histogram_engine;

    localparam int RDL = 3;
    localparam int SB  = 8;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         histogram_en = 1'b0;
    logic [16:0]  num_words = '0;
    logic [15:0]  raddr0, raddr1, s_raddr0, s_raddr1, waddr;
    logic [127:0] rdata0, rdata1, wdata;
    logic         we, busy, hist_done;
    logic [31:0]  tb_clip = '0;
`ifdef HIST_CLIP_EN
    logic [31:0]  clip_excess;
`endif

    histogram_engine #(.RD_LAT(RDL), .SCRATCH_BASE(SB)) dut (
        .clock                        (clock),
        .reset_n                      (reset_n),
        .histogram_en                 (histogram_en),
        .num_words                    (num_words),
        .histogram_input_mem_raddr0   (raddr0),
        .histogram_input_mem_raddr1   (raddr1),
        .histogram_input_mem_rdata0   (rdata0),
        .histogram_input_mem_rdata1   (rdata1),
        .histogram_scratch_mem_raddr0 (s_raddr0),
        .histogram_scratch_mem_raddr1 (s_raddr1),
        .histogram_scratch_mem_waddr  (waddr),
        .histogram_scratch_mem_wdata  (wdata),
        .histogram_scratch_mem_WE     (we),
        .busy                         (busy),
`ifdef HIST_CLIP_EN
        .clip_limit                   (tb_clip),
        .clip_excess                  (clip_excess),
`endif
        .hist_done                    (hist_done)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Input memory with RDL cycles of read latency.
    logic [127:0] mem [64];
    logic [15:0]  a0_q [RDL];
    logic [15:0]  a1_q [RDL];
    initial for (int i = 0; i < RDL; i++) begin a0_q[i] = '0; a1_q[i] = '0; end
    always @(posedge clock) begin
        for (int i = RDL - 1; i > 0; i--) begin
            a0_q[i] <= a0_q[i-1];
            a1_q[i] <= a1_q[i-1];
        end
        a0_q[0] <= raddr0;
        a1_q[0] <= raddr1;
    end
    assign rdata0 = mem[a0_q[RDL-1][5:0]];
    assign rdata1 = mem[a1_q[RDL-1][5:0]];

    // Output monitor (sampled on the falling edge).
    logic [127:0] m_scratch [64];
    int m_done_count = 0, m_done_cyc = 0, m_busy_rises = 0, m_busy_cyc = 0;
    int m_we_total = 0, m_we_run = 0, m_first_we = 0, m_we_err = 0;
    int m_rd_seen = 0, m_rd_max = 0, m_rd_err = 0;
    logic m_prev_busy = 1'b0;
    always @(negedge clock) begin
        int idx;
        if (busy && !m_prev_busy) begin
            m_busy_rises++; m_busy_cyc = cyc; m_rd_seen = 0; m_rd_max = 0;
        end
        m_prev_busy = busy;
        if (busy && !we) begin
            m_rd_seen = 1;
            if (int'(raddr1) > m_rd_max) m_rd_max = int'(raddr1);
            if (raddr1 != raddr0 + 16'd1) m_rd_err++;
        end
        if (we) begin
            if (m_we_run == 0) m_first_we = cyc;
            idx = int'(waddr) - SB;
            if (idx != m_we_run || idx < 0 || idx > 63 || !busy) m_we_err++;
            else m_scratch[idx] = wdata;
            m_we_run++; m_we_total++;
        end else begin
            m_we_run = 0;
        end
        if (hist_done) begin m_done_count++; m_done_cyc = cyc; end
    end

    int n_checks = 0, n_fail = 0;
    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain counting over the frame words.
    int unsigned eb [256];
    int unsigned exp_cx;
    task automatic fill_and_model(input int nw, input int mode);
        logic [127:0] d;
        logic [7:0]   p;
        for (int w = 0; w < 64; w++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            if (w < nw) begin
                for (int k = 0; k < 16; k++) begin
                    case (mode)
                        0: d[8*k +: 8] = 8'(k);
                        1: d[8*k +: 8] = 8'hFF;
                        3: d[8*k +: 8] = 8'($urandom_range(0, 3));
                        4: d[8*k +: 8] = 8'h00;
                        default: d[8*k +: 8] = 8'($urandom);
                    endcase
                end
            end
            mem[w] = d;
        end
        for (int b = 0; b < 256; b++) eb[b] = 0;
        exp_cx = 0;
        for (int w = 0; w < nw; w++) begin
            d = mem[w];
            for (int k = 0; k < 16; k++) begin
                p = d[8*k +: 8];
                if (tb_clip != 0 && eb[p] == tb_clip) begin
                    if (exp_cx != 32'hFFFF_FFFF) exp_cx++;
                end else if (eb[p] != 32'hFFFF_FFFF) begin
                    eb[p]++;
                end
            end
        end
    endtask

    task automatic run_frame(input int nw, input int mode, input string tag);
        int b_done, b_rises, b_weerr, b_rderr, b_wetot, t, exp_lat;
        fill_and_model(nw, mode);
        num_words = 17'(nw);
        b_done = m_done_count; b_rises = m_busy_rises; b_weerr = m_we_err;
        b_rderr = m_rd_err; b_wetot = m_we_total;
        @(posedge clock); #1 histogram_en = 1'b1;
        t = 0;
        while (m_done_count == b_done && t < nw * 40 + 200) begin @(posedge clock); t++; end
        if (m_done_count == b_done) begin
            check_eq({tag, "_done_timeout"}, 128'(m_done_count - b_done), 128'd1);
        end else begin
            repeat (40) @(posedge clock);
            @(negedge clock);
            exp_lat = (nw / 2) * (1 + RDL + 32) + (nw % 2) * (1 + RDL + 16);
            check_eq({tag, "_done_once"}, 128'(m_done_count - b_done), 128'd1);
            check_eq({tag, "_no_restart"}, 128'(m_busy_rises - b_rises), 128'd1);
            check_eq({tag, "_busy_idle"}, 128'(busy), 128'd0);
            check_eq({tag, "_we_count"}, 128'(m_we_total - b_wetot), 128'd64);
            check_eq({tag, "_we_order"}, 128'(m_we_err - b_weerr), 128'd0);
            check_eq({tag, "_done_lat"}, 128'(m_done_cyc - m_first_we), 128'd64);
            check_eq({tag, "_frame_lat"}, 128'(m_first_we - m_busy_cyc), 128'(exp_lat));
            check_eq({tag, "_rd_pair"}, 128'(m_rd_err - b_rderr), 128'd0);
            check_eq({tag, "_rd_seen"}, 128'(m_rd_seen), 128'(nw > 0));
            if (nw > 0) check_eq({tag, "_rd_max"}, 128'(m_rd_max), 128'(2 * ((nw + 1) / 2) - 1));
            for (int i = 0; i < 64; i++) begin
                check_eq($sformatf("%s_word%0d", tag, i), m_scratch[i],
                         {eb[4*i+3], eb[4*i+2], eb[4*i+1], eb[4*i]});
            end
`ifdef HIST_CLIP_EN
            check_eq({tag, "_clip_excess"}, 128'(clip_excess), 128'(exp_cx));
`endif
        end
        #1 histogram_en = 1'b0;
        repeat (2) @(posedge clock);
    endtask

    initial begin
        int t, b_done, b_wetot, b_rises;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check_eq("rst_busy", 128'(busy), 128'd0);
        check_eq("rst_we", 128'(we), 128'd0);
        check_eq("rst_done", 128'(hist_done), 128'd0);
        check_eq("rst_raddr", {raddr1, raddr0, s_raddr1, s_raddr0, waddr}, 128'd0);
        check_eq("rst_wdata", wdata, 128'd0);

        run_frame(16, 0, "uniform");
        check_eq("uniform_w0", m_scratch[0], {32'd16, 32'd16, 32'd16, 32'd16});
        run_frame(3, 1, "odd");
        check_eq("odd_bin255", 128'(m_scratch[63][127:96]), 128'd48);
        run_frame(0, 2, "empty");
        for (int r = 0; r < 5; r++) begin
            run_frame(int'($urandom_range(1, 20)), int'($urandom_range(2, 3)), $sformatf("rand%0d", r));
        end

        // Abort during COUNT of pair 1, then a fresh frame.
        fill_and_model(4, 2);
        num_words = 17'd4;
        b_done = m_done_count; b_wetot = m_we_total; b_rises = m_busy_rises;
        @(posedge clock); #1 histogram_en = 1'b1;
        t = 0;
        while (m_busy_rises == b_rises && t < 20) begin @(negedge clock); t++; end
        check_eq("abort_started", 128'(m_busy_rises - b_rises), 128'd1);
        repeat (50) @(posedge clock);
        #1 histogram_en = 1'b0;
        @(posedge clock); @(negedge clock);
        check_eq("abort_busy", 128'(busy), 128'd0);
        repeat (80) @(posedge clock);
        check_eq("abort_no_we", 128'(m_we_total - b_wetot), 128'd0);
        check_eq("abort_no_done", 128'(m_done_count - b_done), 128'd0);
        run_frame(4, 3, "after_abort");

        // Asynchronous reset during flush word 10.
        fill_and_model(2, 2);
        num_words = 17'd2;
        @(posedge clock); #1 histogram_en = 1'b1;
        t = 0;
        @(negedge clock);
        while (!(we && waddr == 16'(SB + 10)) && t < 300) begin @(negedge clock); t++; end
        check_eq("rstflush_reached", 128'(waddr), 128'(SB + 10));
        #1 reset_n = 1'b0;
        #1;
        check_eq("rstflush_we_async", 128'(we), 128'd0);
        check_eq("rstflush_busy_async", 128'(busy), 128'd0);
        histogram_en = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check_eq("rstflush_outs", {raddr1, raddr0, waddr, 31'd0, we, busy, hist_done}, 128'd0);
        check_eq("rstflush_wdata", wdata, 128'd0);
        run_frame(6, 2, "after_reset");

`ifdef HIST_CLIP_EN
        tb_clip = 32'd5;
        run_frame(1, 4, "clip");
        check_eq("clip_bin0", 128'(m_scratch[0][31:0]), 128'd5);
        check_eq("clip_ex11", 128'(clip_excess), 128'd11);
        tb_clip = 32'd3;
        run_frame(8, 3, "clip_rand");
        tb_clip = 32'd0;
        run_frame(5, 3, "clip_off");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
